audio_sample_scheduler: RTL and testbench
=========================================

// Module: audio_sample_scheduler
// PURPOSE
//  Paces stereo audio into the HDMI transmitter's audio path from the single system clock. A fractional
//  phase accumulator generates the SAMPLE_HZ sample tick and a ~50% duty audio clock, so no gated clock is used.
//  Buffers producer samples in a small FIFO and releases one stereo pair per tick.
//  Handles priming, underrun recovery and enable/disable sequencing.
// PARAMETERS
//  CLK_HZ       30_000_000  frequency of clk; must be > 2*SAMPLE_HZ
//  SAMPLE_HZ    48000       output sample rate
//  WIDTH        24          bits per channel
//  DEPTH        8           FIFO depth in stereo pairs; power of two, >= 2
//  PRIME_LEVEL  4           FIFO occupancy required before playback starts; 1..DEPTH
// PORTS
//  clk            in   1        system clock
//  reset          in   1        synchronous, active-high reset
//  enable         in   1        1 = run scheduler; 0 = idle, flush, mute
//  in_valid       in   1        producer sample valid
//  in_ready       out  1        FIFO can accept (registered: count < DEPTH)
//  in_l / in_r    in   WIDTH    producer left/right sample
//  audio_l        out  WIDTH    current left sample to HDMI audio input
//  audio_r        out  WIDTH    current right sample to HDMI audio input
//  audio_tick     out  1        one-cycle strobe, coincident with new audio_l/r
//  audio_clk      out  1        registered SAMPLE_HZ square wave; rises in the audio_tick cycle
//  playing        out  1        1 while in RUN
//  underruns      out  16       saturating underrun count (stats build only)
//  overruns       out  16       saturating count of in_valid && !in_ready cycles (stats build only)
// BEHAVIOUR
//  Reset: state IDLE, acc=0, FIFO empty, audio_l/r=0, audio_tick=0, audio_clk=0, playing=0,
//    in_ready=0, counters=0.
//  Phase: acc is width clog2(CLK_HZ)+1. While state != IDLE, each cycle nxt = acc + SAMPLE_HZ.
//    If nxt >= CLK_HZ: acc <= nxt - CLK_HZ and the registered audio_tick is 1 the following cycle.
//    Otherwise acc <= nxt. audio_clk <= (acc_next < CLK_HZ/2).
//    In IDLE, acc is held at 0 and no ticks are produced.
//  FIFO push: occurs when in_valid && in_ready. in_ready = (state != IDLE) && count < DEPTH,
//    using the registered count. A pop in the same cycle does not enable a push when full.
//  FIFO pop: occurs only on a tick in RUN, and only when count > 0 (registered). A same-cycle push
//    into an empty FIFO is not bypassed: the tick is an underrun.
//    Simultaneous push and pop leaves count unchanged.
//  States:
//    IDLE:  enable=1 -> PRIME.
//    PRIME: on a tick, audio_l/r <= 0 (mute). When count >= PRIME_LEVEL at a tick -> RUN,
//      and that same tick pops the first sample.
//    RUN:   on a tick with count > 0: pop, audio_l/r <= head.
//      On a tick with count == 0: underrun; hold last audio_l/r, underruns += 1 (saturating at 16'hFFFF),
//      -> PRIME.
//  enable=0 in any state: next cycle -> IDLE, FIFO flushed (count=0), audio_l/r=0, acc=0,
//    audio_clk=0, audio_tick=0, playing=0. Counters retain their values.
//  Reset mid-operation: all state returns to reset values next edge. Any in-flight push is discarded.
//  Latency: a push accepted into an empty, primed FIFO appears on audio_l/r at the first tick
//    whose pop decision sees it, i.e. at least 1 cycle later.
//  Tick spacing: floor or ceil of CLK_HZ/SAMPLE_HZ cycles; long-run rate is exact.
// CONFIGURATION
//  AUDIO_SCHED_STATS_EN defined: underruns/overruns counters are implemented as described.
//  Not defined: counters are removed and underruns/overruns are tied to 16'd0.
//  All other behaviour is identical in both builds.
// TESTING
//  1. CLK_HZ=10, SAMPLE_HZ=3, enable=1 from reset -> ticks at intervals 4,3,3 repeating;
//     exactly 3 ticks per 10 cycles; audio_clk rises with each tick.
//  2. Defaults (30 MHz / 48 kHz) -> audio_tick exactly every 625 cycles.
//     audio_clk is high for 313 cycles and low for 312 cycles of each period.
//  3. PRIME_LEVEL=4: push samples 1..4, values L=n and R=-n -> playing rises at the first tick
//     after the 4th push. Ticks then output (1,-1),(2,-2),(3,-3),(4,-4).
//  4. Starve in RUN: after the last pop, the next tick holds (4,-4), underruns=1, playing=0.
//     The following tick outputs (0,0) from PRIME.
//  5. Fill to DEPTH=8 with no ticks -> in_ready=0. Hold in_valid for 5 cycles -> overruns=5
//     and count stays 8.
//  6. Drop enable mid-RUN with 3 samples queued -> next cycle: IDLE, count=0, audio_l/r=0,
//     no ticks. Re-enable -> PRIME with acc restarted at 0.

Source files
------------

// File: rtl/audio_sample_scheduler_if.sv
// Producer sample handshake and paced HDMI audio outputs of audio_sample_scheduler.
// slave: scheduler side; master: producer/sink side.
interface audio_sample_scheduler_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_l;
  logic [WIDTH-1:0] in_r;
  logic [WIDTH-1:0] audio_l;
  logic [WIDTH-1:0] audio_r;
  logic             audio_tick;
  logic             audio_clk;

  modport master (
    output in_valid, in_l, in_r,
    input  in_ready, audio_l, audio_r, audio_tick, audio_clk
  );

  modport slave (
    input  in_valid, in_l, in_r,
    output in_ready, audio_l, audio_r, audio_tick, audio_clk
  );
endinterface

// File: rtl/audio_sample_scheduler.sv
// Paces stereo samples from a small FIFO using a fractional phase accumulator on one clock.
// Define AUDIO_SCHED_STATS_EN to build the underrun/overrun counters (otherwise tied to 0).
module audio_sample_scheduler #(
  parameter int unsigned CLK_HZ      = 30_000_000,
  parameter int unsigned SAMPLE_HZ   = 48000,
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned PRIME_LEVEL = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  audio_sample_scheduler_if.slave bus,
  output logic                    playing,
  output logic [15:0]             underruns,
  output logic [15:0]             overruns
);
  localparam int unsigned AccW = $clog2(CLK_HZ) + 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [AccW-1:0] ClkHz      = AccW'(CLK_HZ);
  localparam logic [AccW-1:0] SampleHz   = AccW'(SAMPLE_HZ);
  localparam logic [AccW-1:0] HalfClk    = AccW'(CLK_HZ / 2);
  localparam logic [CntW-1:0] Depth      = CntW'(DEPTH);
  localparam logic [CntW-1:0] PrimeLevel = CntW'(PRIME_LEVEL);

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e             state_q, state_d;
  logic [AccW-1:0]    acc_q, acc_d, acc_nxt;
  logic               tick_q, tick_d;
  logic               aclk_q, aclk_d;
  logic [WIDTH-1:0]   audio_l_q, audio_l_d;
  logic [WIDTH-1:0]   audio_r_q, audio_r_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] head;
  logic               wrap, push, pop, in_ready;

  // Both terms are registered, so in_ready never depends on this cycle's inputs.
  assign in_ready = (state_q != StIdle) && (count_q < Depth);
  assign push     = bus.in_valid && in_ready;
  assign acc_nxt  = acc_q + SampleHz;
  assign wrap     = (state_q != StIdle) && (acc_nxt >= ClkHz);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tick_d    = 1'b0;
    aclk_d    = aclk_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        acc_d  = '0;
        aclk_d = 1'b0;
        if (enable) begin
          state_d = StPrime;
        end
      end
      StPrime, StRun: begin
        acc_d  = wrap ? (acc_nxt - ClkHz) : acc_nxt;
        aclk_d = (acc_d < HalfClk);
        tick_d = wrap;
        if (wrap) begin
          if ((count_q != '0) && ((state_q == StRun) || (count_q >= PrimeLevel))) begin
            pop                    = 1'b1;
            state_d                = StRun;
            {audio_l_d, audio_r_d} = head;
          end else if (state_q == StPrime) begin
            audio_l_d = '0;
            audio_r_d = '0;
          end else begin
            // Underrun: keep the last pair on the outputs and re-prime.
            state_d = StPrime;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      state_d   = StIdle;
      acc_d     = '0;
      tick_d    = 1'b0;
      aclk_d    = 1'b0;
      audio_l_d = '0;
      audio_r_d = '0;
      pop       = 1'b0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PtrW'(1)) : wr_ptr_q;
    rd_ptr_d = pop ? (rd_ptr_q + PtrW'(1)) : rd_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    if (!enable) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      tick_q    <= 1'b0;
      aclk_q    <= 1'b0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tick_q    <= tick_d;
      aclk_q    <= aclk_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {bus.in_l, bus.in_r};
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.audio_l    = audio_l_q;
  assign bus.audio_r    = audio_r_q;
  assign bus.audio_tick = tick_q;
  assign bus.audio_clk  = aclk_q;
  assign playing        = (state_q == StRun);

`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0] underruns_q, overruns_q;
  logic        underrun_ev, overrun_ev;

  assign underrun_ev = enable && wrap && (state_q == StRun) && (count_q == '0);
  assign overrun_ev  = bus.in_valid && !in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      underruns_q <= '0;
      overruns_q  <= '0;
    end else begin
      if (underrun_ev && (underruns_q != 16'hFFFF)) begin
        underruns_q <= underruns_q + 16'd1;
      end
      if (overrun_ev && (overruns_q != 16'hFFFF)) begin
        overruns_q <= overruns_q + 16'd1;
      end
    end
  end

  assign underruns = underruns_q;
  assign overruns  = overruns_q;
`else
  assign underruns = 16'd0;
  assign overruns  = 16'd0;
`endif
endmodule

// File: tb/tb_audio_sample_scheduler.sv
// Directed bench: a 10 Hz/3 Hz instance for tick pacing and a default 30 MHz/48 kHz
// instance for FIFO priming, underrun, overrun and enable sequencing.
module tb_audio_sample_scheduler;
  localparam int unsigned W = 24;
`ifdef AUDIO_SCHED_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en_m = 1'b0;
  logic        en_s = 1'b0;
  logic        play_m, play_s;
  logic [15:0] und_m, ovr_m, und_s, ovr_s;

  audio_sample_scheduler_if #(.WIDTH(W)) m_if ();
  audio_sample_scheduler_if #(.WIDTH(W)) s_if ();

  audio_sample_scheduler #(.WIDTH(W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .enable    (en_m),
    .bus       (m_if),
    .playing   (play_m),
    .underruns (und_m),
    .overruns  (ovr_m)
  );

  audio_sample_scheduler #(.CLK_HZ(10), .SAMPLE_HZ(3), .WIDTH(W)) u_small (
    .clk       (clk),
    .reset     (reset),
    .enable    (en_s),
    .bus       (s_if),
    .playing   (play_s),
    .underruns (und_s),
    .overruns  (ovr_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main-instance tick monitor: tick count and audio_clk high cycles per tick period.
  int m_ticks = 0;
  int hi_run = 0;
  int hi_last = 0;
  always @(negedge clk) begin
    if (m_if.audio_tick) begin
      m_ticks <= m_ticks + 1;
      hi_last <= hi_run;
      hi_run  <= int'(m_if.audio_clk);
    end else begin
      hi_run <= hi_run + int'(m_if.audio_clk);
    end
  end

  int s_ticks[8];
  int s_nt = 0;
  int s_bad_aclk = 0;
  always @(negedge clk) begin
    if (s_if.audio_tick) begin
      if (s_nt < 8) s_ticks[s_nt] <= cyc;
      s_nt <= s_nt + 1;
      if (!s_if.audio_clk) s_bad_aclk <= s_bad_aclk + 1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] smp(input int n, input bit negate);
    logic [W-1:0] v;
    v = negate ? W'(-n) : W'(n);
    return 32'(v);
  endfunction

  task automatic push(input int n);
    int t = 0;
    while (!m_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("push_ready", 32'(m_if.in_ready), 32'(1));
    m_if.in_valid = 1'b1;
    m_if.in_l     = smp(n, 1'b0)[W-1:0];
    m_if.in_r     = smp(n, 1'b1)[W-1:0];
    @(negedge clk);
    m_if.in_valid = 1'b0;
  endtask

  task automatic wait_tick(output int at);
    int t = 0;
    @(negedge clk);
    while (!m_if.audio_tick && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("tick_seen", 32'(m_if.audio_tick), 32'(1));
    at = cyc;
    #1;
  endtask

  task automatic chk_out(input string tag, input int n, input bit play, input int und);
    chk({tag, "_l"}, 32'(m_if.audio_l), smp(n, 1'b0));
    chk({tag, "_r"}, 32'(m_if.audio_r), smp(n, 1'b1));
    chk({tag, "_playing"}, 32'(play_m), 32'(play));
    chk({tag, "_underruns"}, 32'(und_m), Stats ? und : 0);
  endtask

  typedef struct {
    int npush;
    int base;
    int exp_n;
    bit exp_play;
    int exp_und;
  } vec_t;

  vec_t vecs[9];
  int   s_exp[6];

  initial begin
    int c0, c2, t_prev, t_now, ticks0;

    vecs[0] = '{4, 1, 1, 1'b1, 0};
    vecs[1] = '{0, 0, 2, 1'b1, 0};
    vecs[2] = '{0, 0, 3, 1'b1, 0};
    vecs[3] = '{0, 0, 4, 1'b1, 0};
    vecs[4] = '{0, 0, 4, 1'b0, 1};
    vecs[5] = '{0, 0, 0, 1'b0, 1};
    vecs[6] = '{2, 5, 0, 1'b0, 1};
    vecs[7] = '{2, 7, 5, 1'b1, 1};
    vecs[8] = '{0, 0, 6, 1'b1, 1};
    s_exp   = '{3, 3, 4, 3, 3, 4};

    m_if.in_valid = 1'b0;
    m_if.in_l     = '0;
    m_if.in_r     = '0;
    s_if.in_valid = 1'b0;
    s_if.in_l     = '0;
    s_if.in_r     = '0;

    repeat (3) @(negedge clk);
    chk_out("reset", 0, 1'b0, 0);
    chk("reset_tick", 32'(m_if.audio_tick), 32'(0));
    chk("reset_aclk", 32'(m_if.audio_clk), 32'(0));
    chk("reset_ready", 32'(m_if.in_ready), 32'(0));
    chk("reset_overruns", 32'(ovr_m), 32'(0));
    reset = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(m_if.in_ready), 32'(0));

    c0     = cyc;
    en_m   = 1'b1;
    en_s   = 1'b1;
    t_prev = c0;
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < vecs[i].npush; k++) push(vecs[i].base + k);
      wait_tick(t_now);
      chk("tick_spacing", 32'(t_now - t_prev), (i == 0) ? 32'd626 : 32'd625);
      if (i > 0) chk("aclk_high_cycles", 32'(hi_last), 32'd313);
      chk("aclk_at_tick", 32'(m_if.audio_clk), 32'(1));
      chk_out("vec", vecs[i].exp_n, vecs[i].exp_play, vecs[i].exp_und);
      t_prev = t_now;
    end

    // Three pairs queued (7,8,9) while running, then disable.
    push(9);
    en_m = 1'b0;
    @(negedge clk);
    chk_out("drop", 0, 1'b0, 1);
    chk("drop_ready", 32'(m_if.in_ready), 32'(0));
    chk("drop_aclk", 32'(m_if.audio_clk), 32'(0));
    chk("drop_tick", 32'(m_if.audio_tick), 32'(0));
    ticks0 = m_ticks;
    repeat (700) @(negedge clk);
    chk("idle_tick_count", 32'(m_ticks - ticks0), 32'd0);

    // Re-enable, fill to full, then hold in_valid against a full FIFO.
    c2   = cyc;
    en_m = 1'b1;
    for (int k = 0; k < 8; k++) push(16 + k);
    chk("full_ready", 32'(m_if.in_ready), 32'(0));
    m_if.in_valid = 1'b1;
    m_if.in_l     = smp(99, 1'b0)[W-1:0];
    m_if.in_r     = smp(99, 1'b1)[W-1:0];
    repeat (5) @(negedge clk);
    m_if.in_valid = 1'b0;
    chk("overruns", 32'(ovr_m), Stats ? 32'd5 : 32'd0);
    chk("full_ready_hold", 32'(m_if.in_ready), 32'(0));
    for (int k = 0; k < 8; k++) begin
      wait_tick(t_now);
      if (k == 0) begin
        chk("reenable_latency", 32'(t_now - c2), 32'd626);
        chk("ready_after_pop", 32'(m_if.in_ready), 32'(1));
      end
      chk_out("drain", 16 + k, 1'b1, 1);
    end
    wait_tick(t_now);
    chk_out("drain_underrun", 23, 1'b0, 2);

    reset = 1'b1;
    @(negedge clk);
    chk_out("midreset", 0, 1'b0, 0);
    chk("midreset_overruns", 32'(ovr_m), 32'(0));
    chk("midreset_ready", 32'(m_if.in_ready), 32'(0));
    reset = 1'b0;

    chk("small_first_tick", 32'(s_ticks[0] - c0), 32'd5);
    for (int i = 0; i < 6; i++) begin
      chk("small_interval", 32'(s_ticks[i + 1] - s_ticks[i]), 32'(s_exp[i]));
    end
    chk("small_3_per_10", 32'(s_ticks[3] - s_ticks[0]), 32'd10);
    chk("small_aclk_at_tick", 32'(s_bad_aclk), 32'd0);
    chk("small_playing", 32'(play_s), 32'(0));
    chk("small_stats", 32'({und_s, ovr_s}), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
